// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types: reset PC default, NOP encoding, inter-stage bus widths
// and the br_bus field layout used by the fetch stage.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEF  = 32'h1C00_0000;
    localparam logic [31:0] NOP_INST      = 32'h0340_0000;
    localparam int          IF_ID_BUS_W   = 64;
    localparam int          BR_BUS_W      = 34;
    localparam int          BR_TAKEN_BIT  = 33;
    localparam int          BR_TARGET_MSB = 32;
    localparam int          BR_TARGET_LSB = 1;
    localparam int          BR_STALL_BIT  = 0;

    // Field order matches the bit offsets above: taken at [33], target at [32:1], stall at [0].
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        stall;
    } br_bus_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_inst_buf.sv
// Holding register for an instruction word whose SRAM response arrived while decode could
// not take it; branch/completion clear has priority over a simultaneous latch.
module if_inst_buf
    import pipe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        latch_en,
    input  logic        clear_en,
    input  logic [31:0] sram_rdata,
    output logic [31:0] inst
);

    logic        buf_valid_r;
    logic [31:0] buf_data_r;

    // Capture the response word and track whether the buffer holds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            buf_data_r  <= 32'h0000_0000;
        end else if (clear_en) begin
            buf_valid_r <= 1'b0;
        end else if (latch_en) begin
            buf_valid_r <= 1'b1;
            buf_data_r  <= sram_rdata;
        end else begin
            buf_valid_r <= buf_valid_r;
        end
    end

    // Present the buffered word if one is held, otherwise the live SRAM response.
    always_comb begin
        inst = sram_rdata;
        if (buf_valid_r) begin
            inst = buf_data_r;
        end else begin
            inst = sram_rdata;
        end
    end

endmodule

// File: rtl/if_unit.sv
// Instruction fetch stage: PC sequencing, branch redirect, stall handling and hand-off to decode.
// Optional misaligned-PC check enabled by defining IF_PC_ALIGN_CHK_EN.
module if_unit
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_Allow_in,
    input  logic [BR_BUS_W-1:0]    br_bus,
    output logic                   inst_sram_en,
    output logic [31:0]            inst_sram_addr,
    input  logic [31:0]            inst_sram_rdata,
    output logic                   IF_to_ID_Valid,
    output logic [IF_ID_BUS_W-1:0] IF_to_ID_Bus,
    output logic                   fetch_err
);

    br_bus_t     br_s;
    logic [31:0] fs_pc_r;
    logic        fs_valid_r;
    logic        resp_pend_r;
    logic [31:0] nextpc_s;
    logic        fs_ready_go_s;
    logic        fs_allow_in_s;
    logic        xfer_done_s;
    logic        buf_latch_s;
    logic        buf_clear_s;
    logic [31:0] buf_inst_s;
    logic [31:0] inst_s;

    assign br_s = br_bus;

    // Next-PC selection, handshake and fetch request generation.
    always_comb begin
        nextpc_s      = fs_pc_r + 32'd4;
        fs_ready_go_s = ~br_s.stall;
        fs_allow_in_s = ~fs_valid_r | (fs_ready_go_s & ID_Allow_in);
        if (br_s.taken) begin
            nextpc_s = br_s.target;
        end else begin
            nextpc_s = fs_pc_r + 32'd4;
        end
        inst_sram_en   = ~reset & (fs_allow_in_s | br_s.taken);
        inst_sram_addr = nextpc_s;
        IF_to_ID_Valid = ~reset & fs_valid_r & fs_ready_go_s & ~br_s.taken;
        xfer_done_s    = IF_to_ID_Valid & ID_Allow_in;
        // The SRAM word is only valid the cycle after its request; keep it if decode won't take it now.
        buf_latch_s    = fs_valid_r & resp_pend_r & ~xfer_done_s;
        buf_clear_s    = xfer_done_s | br_s.taken;
    end

    // Fetch-stage PC/valid and the one-cycle response-pending flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_pc_r     <= RESET_PC - 32'd4;
            fs_valid_r  <= 1'b0;
            resp_pend_r <= 1'b0;
        end else if (inst_sram_en) begin
            fs_pc_r     <= nextpc_s;
            fs_valid_r  <= 1'b1;
            resp_pend_r <= 1'b1;
        end else begin
            fs_pc_r     <= fs_pc_r;
            fs_valid_r  <= fs_valid_r;
            resp_pend_r <= 1'b0;
        end
    end

    if_inst_buf u_inst_buf (
        .clk        (clk),
        .reset      (reset),
        .latch_en   (buf_latch_s),
        .clear_en   (buf_clear_s),
        .sram_rdata (inst_sram_rdata),
        .inst       (buf_inst_s)
    );

`ifdef IF_PC_ALIGN_CHK_EN
    logic fetch_err_r;

    // Substitute a NOP for a misaligned fetch so decode never sees a garbage word.
    always_comb begin
        inst_s = buf_inst_s;
        if (pc_misaligned(fs_pc_r)) begin
            inst_s = NOP_INST;
        end else begin
            inst_s = buf_inst_s;
        end
    end

    // Sticky error flag, set when a misaligned instruction is handed to decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_err_r <= 1'b0;
        end else if (xfer_done_s && pc_misaligned(fs_pc_r)) begin
            fetch_err_r <= 1'b1;
        end else begin
            fetch_err_r <= fetch_err_r;
        end
    end

    assign fetch_err = fetch_err_r;
`else
    assign inst_s    = buf_inst_s;
    assign fetch_err = 1'b0;
`endif

    assign IF_to_ID_Bus = {fs_pc_r, inst_s};

endmodule

// File: doc/if_unit.md
IF_UNIT -- requirements
Module: if_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h1C00_0000, first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port ID_Allow_in, input, 1, decode stage can accept an instruction this cycle.
REQ-005 SHALL have port br_bus, input, 34: [33] br_taken, [32:1] br_target, [0] br_stall.
REQ-006 SHALL have port inst_sram_en, output, 1, fetch request this cycle.
REQ-007 SHALL have port inst_sram_addr, output, 32, fetch address.
REQ-008 SHALL have port inst_sram_rdata, input, 32, instruction word, valid exactly one cycle after an accepted request.
REQ-009 SHALL have port IF_to_ID_Valid, output, 1, IF_to_ID_Bus holds a deliverable instruction.
REQ-010 SHALL have port IF_to_ID_Bus, output, 64, {pc[63:32], inst[31:0]}.
REQ-011 SHALL have port fetch_err, output, 1, sticky misaligned-fetch flag (see Configuration).

Function
REQ-012 SHALL hold fs_pc (32) and fs_valid (1); fs_pc is the address of the instruction currently in IF.
REQ-013 SHALL compute nextpc = br_taken ? br_target : fs_pc + 4, with wrap-around modulo 2^32.
REQ-014 SHALL compute fs_ready_go = ~br_stall and fs_allow_in = ~fs_valid | (fs_ready_go & ID_Allow_in).
REQ-015 SHALL assert inst_sram_en = ~reset & (fs_allow_in | br_taken), with inst_sram_addr = nextpc, combinationally.
REQ-016 SHALL load fs_pc <= nextpc and fs_valid <= 1 on every cycle where inst_sram_en = 1.
REQ-017 SHALL drive IF_to_ID_Valid = fs_valid & fs_ready_go & ~br_taken.
REQ-018 SHALL discard the IF instruction in a br_taken cycle; it is never delivered, and the target fetch follows next cycle.
REQ-019 SHALL provide a 32-bit instruction buffer plus buf_valid: when fs_valid and the SRAM response arrives but the transfer is not completed (IF_to_ID_Valid & ID_Allow_in = 0), latch inst_sram_rdata and set buf_valid.
REQ-020 SHALL output inst = buf_valid ? buffer : inst_sram_rdata.
REQ-021 SHALL clear buf_valid on a completed transfer (IF_to_ID_Valid & ID_Allow_in) or on br_taken; br_taken wins over a simultaneous latch.
REQ-022 SHALL never lose or duplicate an instruction across any sequence of ID_Allow_in/br_stall deassertion.
REQ-023 SHALL deliver a sequential stream with one instruction per cycle when ID_Allow_in = 1 and br_stall = 0.

Reset
REQ-024 SHALL set fs_pc = RESET_PC - 4, fs_valid = 0, buf_valid = 0, and fetch_err = 0 while reset = 1.
REQ-025 SHALL hold inst_sram_en = 0 and IF_to_ID_Valid = 0 while reset = 1.
REQ-026 SHALL issue the first request to RESET_PC in the first cycle after reset deasserts.
REQ-027 SHALL treat reset in mid-stream as absolute: in-flight, buffered, and branch state is discarded.

Configuration
REQ-028 SHALL, with IF_PC_ALIGN_CHK_EN defined, replace inst with NOP 32'h0340_0000 when fs_pc[1:0] != 0 and set fetch_err on delivery.
REQ-029 SHALL, with IF_PC_ALIGN_CHK_EN undefined, tie fetch_err to 0 and pass the fetched word unmodified.

Structure
REQ-030 SHALL take RESET_PC default, the NOP encoding, bus widths (64, 34), and br_bus field offsets from shared package pipe_pkg.
REQ-031 SHALL place the instruction buffer (REQ-019..021) in sub-module if_inst_buf.

Verification
REQ-032 SHALL cover reset release with ID_Allow_in = 1 -> requests to 0x1C000000, 0x1C000004, 0x1C000008 on consecutive cycles; IF_to_ID_Valid is first asserted one cycle after the first request.
REQ-033 SHALL cover ID_Allow_in = 0 for 3 cycles while holding pc 0x1C000008 -> inst_sram_en = 0, bus stable with the buffered word, then 0x1C00000C follows with no gap or duplicate.
REQ-034 SHALL cover br_taken = 1 with target 0x1C000100 while IF holds 0x1C000010 -> 0x1C000010 is never delivered; next delivered pc = 0x1C000100.
REQ-035 SHALL cover br_stall = 1 for 2 cycles -> IF_to_ID_Valid = 0 and the same instruction is presented afterward.
REQ-036 SHALL cover br_taken in the same cycle as a buffer latch -> buf_valid = 0 next cycle; target instruction is delivered from SRAM.
REQ-037 SHALL cover, with IF_PC_ALIGN_CHK_EN, target 0x1C000102 -> inst = 32'h0340_0000 and fetch_err = 1 and stays set.
